// File: rtl/axi_pkg.sv
// Shared AXI tie-off constants, transfer size codes and bridge FSM encoding.
package axi_pkg;

  localparam logic [3:0] AXI_ID         = 4'd0;
  localparam logic [7:0] AXI_LEN        = 8'd0;
  localparam logic [2:0] AXI_SIZE_UNUSED = 3'd0;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_LOCK       = 2'b00;
  localparam logic [3:0] AXI_CACHE      = 4'b0000;
  localparam logic [2:0] AXI_PROT       = 3'b000;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StAr   = 3'd1,
    StR    = 3'd2,
    StAwW  = 3'd3,
    StB    = 3'd4
  } bridge_state_e;

endpackage

// File: rtl/sram_axi_bridge_if.sv
// Cache-side sram-like bus and SoC-side single-beat AXI bus.
interface sram_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  cache_req;
  logic                  cache_wr;
  logic [1:0]            cache_size;
  logic [ADDR_WIDTH-1:0] cache_addr;
  logic [DATA_WIDTH-1:0] cache_wdata;
  logic [DATA_WIDTH-1:0] cache_rdata;
  logic                  cache_addr_ok;
  logic                  cache_data_ok;

  modport master (
    output cache_req, cache_wr, cache_size, cache_addr, cache_wdata,
    input  cache_rdata, cache_addr_ok, cache_data_ok
  );
  modport slave (
    input  cache_req, cache_wr, cache_size, cache_addr, cache_wdata,
    output cache_rdata, cache_addr_ok, cache_data_ok
  );
endinterface

interface axi_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [3:0]              arid, awid;
  logic [7:0]              arlen, awlen;
  logic [1:0]              arburst, awburst, arlock, awlock;
  logic [3:0]              arcache, awcache;
  logic [2:0]              arprot, awprot;
  logic [ADDR_WIDTH-1:0]   araddr, awaddr;
  logic [2:0]              arsize, awsize;
  logic                    arvalid, arready;
  logic [DATA_WIDTH-1:0]   rdata, wdata;
  logic [1:0]              rresp, bresp;
  logic                    rvalid, rready;
  logic                    awvalid, awready;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast, wvalid, wready;
  logic                    bvalid, bready;

  modport master (
    output arid, arlen, arburst, arlock, arcache, arprot, araddr, arsize, arvalid,
    output awid, awlen, awburst, awlock, awcache, awprot, awaddr, awsize, awvalid,
    output rready, wdata, wstrb, wlast, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
  modport slave (
    input  arid, arlen, arburst, arlock, arcache, arprot, araddr, arsize, arvalid,
    input  awid, awlen, awburst, awlock, awcache, awprot, awaddr, awsize, awvalid,
    input  rready, wdata, wstrb, wlast, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/sram_wstrb_gen.sv
// Byte-lane strobe decode from transfer size and low address bits (32-bit bus).
module sram_wstrb_gen
  import axi_pkg::*;
(
  input  logic [1:0] size,
  input  logic [1:0] offset,
  output logic [3:0] wstrb
);

  always_comb begin
    wstrb = 4'b1111;
    case (size)
      SIZE_BYTE: wstrb = 4'b0001 << offset;
      SIZE_HALF: wstrb = offset[1] ? 4'b1100 : 4'b0011;
      default:   wstrb = 4'b1111;
    endcase
  end

endmodule

// File: rtl/sram_axi_bridge.sv
// sram-like cache responder issuing one single-beat AXI read or write at a time.
module sram_axi_bridge
  import axi_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic   clk,
  input  logic   resetn,
  sram_if.slave  cache,
  axi_if.master  axi
);

  bridge_state_e         state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [1:0]            size_q, size_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [3:0]            wstrb_q, wstrb_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  data_ok_q, data_ok_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q, w_done_d;
  logic [3:0]            req_wstrb;
  logic                  addr_ok;
  logic                  unused_resp;

  // Error responses are deliberately not reported back to the cache.
  assign unused_resp = ^{axi.rresp, axi.bresp};

  sram_wstrb_gen u_wstrb_gen (
    .size   (cache.cache_size),
    .offset (cache.cache_addr[1:0]),
    .wstrb  (req_wstrb)
  );

  assign addr_ok = cache.cache_req && (state_q == StIdle);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    size_d    = size_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rdata_d   = rdata_q;
    data_ok_d = 1'b0;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    unique case (state_q)
      StIdle: begin
        if (addr_ok) begin
          addr_d    = cache.cache_addr;
          size_d    = cache.cache_size;
          wdata_d   = cache.cache_wdata;
          wstrb_d   = req_wstrb;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = cache.cache_wr ? StAwW : StAr;
        end
      end
      StAr: if (axi.arready) state_d = StR;
      StR: begin
        if (axi.rvalid) begin
          rdata_d   = axi.rdata;
          data_ok_d = 1'b1;
          state_d   = StIdle;
        end
      end
      StAwW: begin
        aw_done_d = aw_done_q | axi.awready;
        w_done_d  = w_done_q | axi.wready;
        if (aw_done_d && w_done_d) state_d = StB;
      end
      StB: begin
        if (axi.bvalid) begin
          data_ok_d = 1'b1;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      size_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      data_ok_q <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      size_q    <= size_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rdata_q   <= rdata_d;
      data_ok_q <= data_ok_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  assign cache.cache_addr_ok = addr_ok;
  assign cache.cache_data_ok = data_ok_q;
  assign cache.cache_rdata   = rdata_q;

  // Valids decode straight from state so an async reset drops them at once.
  assign axi.arvalid = (state_q == StAr);
  assign axi.rready  = (state_q == StR);
  assign axi.awvalid = (state_q == StAwW) && !aw_done_q;
  assign axi.wvalid  = (state_q == StAwW) && !w_done_q;
  assign axi.bready  = (state_q == StB);

  assign axi.araddr  = addr_q;
  assign axi.awaddr  = addr_q;
  assign axi.arsize  = {1'b0, size_q};
  assign axi.awsize  = {1'b0, size_q};
  assign axi.wdata   = wdata_q;
  assign axi.wstrb   = wstrb_q;
  assign axi.wlast   = 1'b1;

  assign axi.arid    = AXI_ID;
  assign axi.awid    = AXI_ID;
  assign axi.arlen   = AXI_LEN;
  assign axi.awlen   = AXI_LEN;
  assign axi.arburst = AXI_BURST_INCR;
  assign axi.awburst = AXI_BURST_INCR;
  assign axi.arlock  = AXI_LOCK;
  assign axi.awlock  = AXI_LOCK;
  assign axi.arcache = AXI_CACHE;
  assign axi.awcache = AXI_CACHE;
  assign axi.arprot  = AXI_PROT;
  assign axi.awprot  = AXI_PROT;

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Directed bench for sram_axi_bridge: reads, writes, handshake ordering, reset abort.
module tb_sram_axi_bridge;

  logic clk;
  logic resetn;
  int   checks;
  int   errors;

  sram_if cache_bus ();
  axi_if  axi_bus ();

  sram_axi_bridge dut (
    .clk    (clk),
    .resetn (resetn),
    .cache  (cache_bus),
    .axi    (axi_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic req(input logic v, input logic wr, input logic [1:0] size,
                     input logic [31:0] addr, input logic [31:0] wdata);
    cache_bus.cache_req   = v;
    cache_bus.cache_wr    = wr;
    cache_bus.cache_size  = size;
    cache_bus.cache_addr  = addr;
    cache_bus.cache_wdata = wdata;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    resetn = 1'b0;
    req(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    axi_bus.arready = 0; axi_bus.rvalid = 0; axi_bus.rdata = 0; axi_bus.rresp = 0;
    axi_bus.awready = 0; axi_bus.wready = 0; axi_bus.bvalid = 0; axi_bus.bresp = 0;
    #2;
    check("rst_arvalid", {31'd0, axi_bus.arvalid}, 0);
    check("rst_awvalid", {31'd0, axi_bus.awvalid}, 0);
    check("rst_wvalid", {31'd0, axi_bus.wvalid}, 0);
    check("rst_data_ok", {31'd0, cache_bus.cache_data_ok}, 0);
    check("rst_rdata", cache_bus.cache_rdata, 0);
    check("rst_wstrb", {28'd0, axi_bus.wstrb}, 0);
    step(); resetn = 1'b1;

    // 1: word read, arready after 2 cycles
    step(); req(1, 0, 2'd2, 32'h1FC0_0004, 32'h0); #1;
    check("t1_addr_ok", {31'd0, cache_bus.cache_addr_ok}, 1);
    step(); req(0, 0, 2'd0, 32'h0, 32'h0); #1;
    check("t1_arvalid", {31'd0, axi_bus.arvalid}, 1);
    check("t1_araddr", axi_bus.araddr, 32'h1FC0_0004);
    check("t1_arsize", {29'd0, axi_bus.arsize}, 2);
    step(); #1;
    check("t1_arvalid_hold", {31'd0, axi_bus.arvalid}, 1);
    step(); axi_bus.arready = 1; #1;
    check("t1_arvalid_hs", {31'd0, axi_bus.arvalid}, 1);
    step(); axi_bus.arready = 0; axi_bus.rvalid = 1; axi_bus.rdata = 32'hDEAD_BEEF; #1;
    check("t1_rready", {31'd0, axi_bus.rready}, 1);
    check("t1_arvalid_off", {31'd0, axi_bus.arvalid}, 0);
    check("t1_no_early_ok", {31'd0, cache_bus.cache_data_ok}, 0);
    step(); axi_bus.rvalid = 0; axi_bus.rdata = 0; #1;
    check("t1_data_ok", {31'd0, cache_bus.cache_data_ok}, 1);
    check("t1_rdata", cache_bus.cache_rdata, 32'hDEAD_BEEF);
    check("t1_rready_off", {31'd0, axi_bus.rready}, 0);
    step(); #1;
    check("t1_ok_pulse", {31'd0, cache_bus.cache_data_ok}, 0);
    check("t1_rdata_held", cache_bus.cache_rdata, 32'hDEAD_BEEF);

    // 2: byte write at offset 3
    step(); req(1, 1, 2'd0, 32'h0000_1003, 32'hAB00_0000); #1;
    check("t2_addr_ok", {31'd0, cache_bus.cache_addr_ok}, 1);
    step(); req(0, 0, 2'd0, 32'h0, 32'h0); axi_bus.awready = 1; axi_bus.wready = 1; #1;
    check("t2_awvalid", {31'd0, axi_bus.awvalid}, 1);
    check("t2_wvalid", {31'd0, axi_bus.wvalid}, 1);
    check("t2_wstrb", {28'd0, axi_bus.wstrb}, 4'b1000);
    check("t2_awsize", {29'd0, axi_bus.awsize}, 0);
    check("t2_awaddr", axi_bus.awaddr, 32'h0000_1003);
    check("t2_wdata", axi_bus.wdata, 32'hAB00_0000);
    step(); axi_bus.awready = 0; axi_bus.wready = 0; axi_bus.bvalid = 1; #1;
    check("t2_valids_off", {30'd0, axi_bus.awvalid, axi_bus.wvalid}, 0);
    check("t2_bready", {31'd0, axi_bus.bready}, 1);
    step(); axi_bus.bvalid = 0; #1;
    check("t2_data_ok", {31'd0, cache_bus.cache_data_ok}, 1);
    check("t2_bready_off", {31'd0, axi_bus.bready}, 0);
    step(); #1;
    check("t2_ok_pulse", {31'd0, cache_bus.cache_data_ok}, 0);

    // 3: W handshakes first, AW three cycles later
    step(); req(1, 1, 2'd2, 32'h0000_2000, 32'h1234_5678); #1;
    check("t3_addr_ok", {31'd0, cache_bus.cache_addr_ok}, 1);
    step(); req(0, 0, 2'd0, 32'h0, 32'h0); axi_bus.wready = 1; #1;
    check("t3_both_valid", {30'd0, axi_bus.awvalid, axi_bus.wvalid}, 2'b11);
    step(); axi_bus.wready = 0; #1;
    check("t3_w_dropped", {30'd0, axi_bus.awvalid, axi_bus.wvalid}, 2'b10);
    step(); #1;
    check("t3_aw_hold", {30'd0, axi_bus.awvalid, axi_bus.bready}, 2'b10);
    step(); axi_bus.awready = 1; #1;
    check("t3_aw_hs", {30'd0, axi_bus.awvalid, axi_bus.wvalid}, 2'b10);
    step(); axi_bus.awready = 0; axi_bus.bvalid = 1; #1;
    check("t3_in_b", {29'd0, axi_bus.awvalid, axi_bus.bready, cache_bus.cache_data_ok}, 3'b010);
    step(); axi_bus.bvalid = 0; #1;
    check("t3_data_ok", {31'd0, cache_bus.cache_data_ok}, 1);
    step(); #1;
    check("t3_one_ok", {31'd0, cache_bus.cache_data_ok}, 0);

    // 4: back-to-back read then half write, req held high
    step(); req(1, 0, 2'd2, 32'h0000_0100, 32'h0); #1;
    check("t4_addr_ok0", {31'd0, cache_bus.cache_addr_ok}, 1);
    step(); req(1, 1, 2'd1, 32'h0000_0002, 32'hBEEF_0000); axi_bus.arready = 1; #1;
    check("t4_no_accept_ar", {31'd0, cache_bus.cache_addr_ok}, 0);
    step(); axi_bus.arready = 0; axi_bus.rvalid = 1; axi_bus.rdata = 32'h55AA_55AA; #1;
    check("t4_no_accept_r", {31'd0, cache_bus.cache_addr_ok}, 0);
    step(); axi_bus.rvalid = 0; #1;
    check("t4_ok_and_accept", {30'd0, cache_bus.cache_data_ok, cache_bus.cache_addr_ok}, 2'b11);
    check("t4_rdata", cache_bus.cache_rdata, 32'h55AA_55AA);
    step(); req(0, 0, 2'd0, 32'h0, 32'h0); axi_bus.awready = 1; axi_bus.wready = 1; #1;
    check("t4_wstrb", {28'd0, axi_bus.wstrb}, 4'b1100);
    check("t4_awaddr", axi_bus.awaddr, 32'h0000_0002);
    check("t4_awsize", {29'd0, axi_bus.awsize}, 1);
    check("t4_wdata", axi_bus.wdata, 32'hBEEF_0000);
    step(); axi_bus.awready = 0; axi_bus.wready = 0; axi_bus.bvalid = 1; #1;
    check("t4_bready", {31'd0, axi_bus.bready}, 1);
    step(); axi_bus.bvalid = 0; #1;
    check("t4_data_ok", {31'd0, cache_bus.cache_data_ok}, 1);

    // 5: reset while in R with rvalid pending
    step(); req(1, 0, 2'd2, 32'h0000_3000, 32'h0); #1;
    check("t5_addr_ok", {31'd0, cache_bus.cache_addr_ok}, 1);
    step(); req(0, 0, 2'd0, 32'h0, 32'h0); axi_bus.arready = 1; #1;
    step(); axi_bus.arready = 0; axi_bus.rvalid = 1; axi_bus.rdata = 32'h1111_1111; #1;
    check("t5_rready_pre", {31'd0, axi_bus.rready}, 1);
    resetn = 1'b0; #1;
    check("t5_rready_rst", {31'd0, axi_bus.rready}, 0);
    check("t5_arvalid_rst", {31'd0, axi_bus.arvalid}, 0);
    check("t5_data_ok_rst", {31'd0, cache_bus.cache_data_ok}, 0);
    check("t5_rdata_rst", cache_bus.cache_rdata, 0);
    step(); axi_bus.rvalid = 0; resetn = 1'b1; req(1, 0, 2'd2, 32'h0000_3004, 32'h0); #1;
    check("t5_accept_after", {31'd0, cache_bus.cache_addr_ok}, 1);
    check("t5_no_stale_ok", {31'd0, cache_bus.cache_data_ok}, 0);

    // 6: error response still completes with data passed through
    step(); req(0, 0, 2'd0, 32'h0, 32'h0); axi_bus.arready = 1; #1;
    check("t6_araddr", axi_bus.araddr, 32'h0000_3004);
    step(); axi_bus.arready = 0; axi_bus.rvalid = 1; axi_bus.rresp = 2'b10;
    axi_bus.rdata = 32'hCAFE_F00D; #1;
    step(); axi_bus.rvalid = 0; axi_bus.rresp = 0; #1;
    check("t6_data_ok", {31'd0, cache_bus.cache_data_ok}, 1);
    check("t6_rdata", cache_bus.cache_rdata, 32'hCAFE_F00D);
    step(); #1;
    check("t6_idle", {29'd0, axi_bus.arvalid, axi_bus.rready, cache_bus.cache_data_ok}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
